// File: rtl/asp_reliable_if.sv
// Host/network signal bundle for asp_reliable.
// slave = bridge side, master = host/network side.
interface asp_reliable_if #(
  parameter int data_size = 32,
  parameter int tag_size  = 8
);
  logic                          data_parity_ready_in;
  logic [data_size:0]            data_parity_in;
  logic                          network_data_ready_in;
  logic                          network_ACK_in;
  logic [data_size+tag_size-1:0] network_data_tag_in;
  logic                          parity_error_out;
  logic                          overflow_out;
  logic                          drop_out;
  logic                          host_data_ready_out;
  logic [data_size-1:0]          host_data_out;
  logic                          network_data_ready_out;
  logic                          network_ACK_out;
  logic [data_size+tag_size-1:0] network_data_tag_out;

  modport slave (
    input  data_parity_ready_in,
    input  data_parity_in,
    input  network_data_ready_in,
    input  network_ACK_in,
    input  network_data_tag_in,
    output parity_error_out,
    output overflow_out,
    output drop_out,
    output host_data_ready_out,
    output host_data_out,
    output network_data_ready_out,
    output network_ACK_out,
    output network_data_tag_out
  );

  modport master (
    output data_parity_ready_in,
    output data_parity_in,
    output network_data_ready_in,
    output network_ACK_in,
    output network_data_tag_in,
    input  parity_error_out,
    input  overflow_out,
    input  drop_out,
    input  host_data_ready_out,
    input  host_data_out,
    input  network_data_ready_out,
    input  network_ACK_out,
    input  network_data_tag_out
  );
endinterface

// File: rtl/asp_reliable.sv
// Reliable ASP bridge: parity-checked host words are tagged, queued and
// retransmitted until ACKed; network words are ACKed and de-duplicated.
// Ports: clk, reset (async, active-high), bus (asp_reliable_if.slave).
module asp_reliable #(
  parameter int data_size   = 32,
  parameter int tag_size    = 8,
  parameter int depth       = 4,
  parameter int timeout     = 16,
  parameter int max_retries = 3,
  parameter int parity_odd  = 0
) (
  input  logic          clk,
  input  logic          reset,
  asp_reliable_if.slave bus
);
  localparam int w  = data_size + tag_size;
  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam int tw = $clog2(timeout);
  localparam int rw = (max_retries > 0) ? $clog2(max_retries + 1) : 1;
  localparam logic          odd    = (parity_odd != 0);
  localparam logic [cw-1:0] full_c = cw'(depth);
  localparam logic [tw-1:0] t_last = tw'(timeout - 1);
  localparam logic [rw-1:0] r_max  = rw'(max_retries);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

  logic [w-1:0]        mem [depth];
  logic [aw-1:0]       wr_ptr;
  logic [aw-1:0]       rd_ptr;
  logic [cw-1:0]       count;
  logic [tag_size-1:0] seq;
  state_t              state;
  logic [tw-1:0]       timer;
  logic [rw-1:0]       retry;
  logic [tag_size-1:0] last_tag;
  logic                last_valid;

  logic                good;
  logic                full;
  logic                push;
  logic                pop;
  logic                expired;
  logic [w-1:0]        head;
  logic [tag_size-1:0] rx_tag;
  logic [data_size-1:0] rx_data;

  assign good    = bus.data_parity_ready_in
                 && ((^bus.data_parity_in) == odd);
  assign full    = (count == full_c);
  assign push    = good && !full;
  assign expired = (timer == t_last);
  assign pop     = (state == WAIT_ACK)
                 && (bus.network_ACK_in
                     || (expired && retry == r_max));
  assign head    = mem[rd_ptr];
  assign rx_tag  = bus.network_data_tag_in[w-1:data_size];
  assign rx_data = bus.network_data_tag_in[data_size-1:0];

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {seq, bus.data_parity_in[data_size-1:0]};
  end

  // Host ingress and queue bookkeeping; full is judged before the pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      count                <= '0;
      seq                  <= '0;
      bus.parity_error_out <= 1'b0;
      bus.overflow_out     <= 1'b0;
    end else begin
      bus.parity_error_out <= bus.data_parity_ready_in && !good;
      bus.overflow_out     <= good && full;
      if (push) begin
        wr_ptr <= wr_ptr + aw'(1);
        seq    <= seq + tag_size'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + aw'(1);
      count <= count + cw'(push) - cw'(pop);
    end
  end

  // Transmit FSM; an ACK wins over a simultaneous timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                      <= IDLE;
      timer                      <= '0;
      retry                      <= '0;
      bus.network_data_ready_out <= 1'b0;
      bus.network_data_tag_out   <= '0;
      bus.drop_out               <= 1'b0;
    end else begin
      bus.network_data_ready_out <= 1'b0;
      bus.drop_out               <= 1'b0;
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            state                      <= SEND;
            retry                      <= '0;
            bus.network_data_ready_out <= 1'b1;
            bus.network_data_tag_out   <= head;
          end
        end
        SEND: begin
          state <= WAIT_ACK;
          timer <= '0;
        end
        WAIT_ACK: begin
          if (bus.network_ACK_in) begin
            state <= IDLE;
          end else if (expired) begin
            if (retry == r_max) begin
              state        <= IDLE;
              bus.drop_out <= 1'b1;
            end else begin
              state                      <= SEND;
              retry                      <= retry + rw'(1);
              bus.network_data_ready_out <= 1'b1;
              bus.network_data_tag_out   <= head;
            end
          end else begin
            timer <= timer + tw'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Receive path: every word is ACKed, repeats of the last tag are
  // not re-delivered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_tag                <= '0;
      last_valid              <= 1'b0;
      bus.network_ACK_out     <= 1'b0;
      bus.host_data_ready_out <= 1'b0;
      bus.host_data_out       <= '0;
    end else begin
      bus.network_ACK_out     <= bus.network_data_ready_in;
      bus.host_data_ready_out <= 1'b0;
      if (bus.network_data_ready_in
          && !(last_valid && rx_tag == last_tag)) begin
        bus.host_data_out       <= rx_data;
        bus.host_data_ready_out <= 1'b1;
        last_tag                <= rx_tag;
        last_valid              <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_asp_reliable.sv
// Self-checking bench for asp_reliable.
// Drives host/network traffic and compares against a queue-based model.
module tb_asp_reliable;
  localparam int DW   = 32;
  localparam int TW   = 8;
  localparam int DEP  = 4;
  localparam int TMO  = 16;
  localparam int MAXR = 3;
  localparam int ODD  = 0;
  localparam int OW   = 6 + 2 * DW + TW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  asp_reliable_if #(.data_size(DW), .tag_size(TW)) bus();

  asp_reliable #(
    .data_size(DW), .tag_size(TW), .depth(DEP),
    .timeout(TMO), .max_retries(MAXR), .parity_odd(ODD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int checks = 0;
  int fails  = 0;

  int seq;
  logic [DW+TW-1:0] q[$];
  logic last_valid;
  logic [TW-1:0] last_tag;
  logic [DW-1:0] held;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW:0] word(input logic [DW-1:0] d,
                                       input bit ok);
    logic p;
    p = (^d) ^ (ODD != 0);
    if (!ok) p = ~p;
    return {p, d};
  endfunction

  function automatic logic [OW-1:0] outs();
    return {bus.parity_error_out, bus.overflow_out, bus.drop_out,
            bus.host_data_ready_out, bus.host_data_out,
            bus.network_data_ready_out, bus.network_ACK_out,
            bus.network_data_tag_out};
  endfunction

  task automatic model_reset;
    seq = 0;
    q.delete();
    last_valid = 1'b0;
    last_tag = '0;
    held = '0;
  endtask

  task automatic do_reset;
    bus.data_parity_ready_in  = 1'b0;
    bus.data_parity_in        = '0;
    bus.network_data_ready_in = 1'b0;
    bus.network_ACK_in        = 1'b0;
    bus.network_data_tag_in   = '0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    model_reset;
  endtask

  task automatic push(input logic [DW:0] w);
    bus.data_parity_ready_in = 1'b1;
    bus.data_parity_in = w;
    tick;
    bus.data_parity_ready_in = 1'b0;
  endtask

  task automatic wait_send(input int n, output bit found,
                           output logic [DW+TW-1:0] td);
    found = 1'b0;
    td = '0;
    for (int i = 0; i <= n && !found; i++) begin
      if (bus.network_data_ready_out) begin
        found = 1'b1;
        td = bus.network_data_tag_out;
      end else begin
        tick;
      end
    end
  endtask

  // Called in the SEND cycle: ACK in the first WAIT_ACK cycle.
  task automatic do_ack;
    tick;
    bus.network_ACK_in = 1'b1;
    tick;
    bus.network_ACK_in = 1'b0;
  endtask

  task automatic count_activity(input int n, output int sends,
                                output int drops);
    sends = 0;
    drops = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.network_data_ready_out) sends++;
      if (bus.drop_out) drops++;
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.data_parity_ready_in = 1'b1;
    bus.data_parity_in = word(32'h1, 1);
    bus.network_data_ready_in = 1'b1;
    bus.network_ACK_in = 1'b0;
    bus.network_data_tag_in = '1;
    tick;
    tick;
    checks++;
    if (outs() !== '0) begin
      fails++;
      $display("FAIL reset_outputs got %h want 0", outs());
    end
    do_reset;
  endtask

  task automatic test_parity;
    bit f;
    logic [DW+TW-1:0] td;
    int s, d;
    do_reset;
    push({1'b0, 32'h0000_00A5});
    checks++;
    if (bus.parity_error_out !== 1'b0) begin
      fails++;
      $display("FAIL parity_good got %b want 0", bus.parity_error_out);
    end
    push({1'b0, 32'h0000_00A4});
    checks++;
    if (bus.parity_error_out !== 1'b1) begin
      fails++;
      $display("FAIL parity_bad got %b want 1", bus.parity_error_out);
    end
    wait_send(4, f, td);
    checks++;
    if (f !== 1'b1 || td !== {8'h00, 32'h0000_00A5}) begin
      fails++;
      $display("FAIL parity_send got %b/%h want 1/%h",
               f, td, {8'h00, 32'h0000_00A5});
    end
    if (f) do_ack;
    count_activity(40, s, d);
    checks++;
    if (s != 0) begin
      fails++;
      $display("FAIL parity_bad_sent got %0d sends want 0", s);
    end
  endtask

  task automatic test_retry;
    int np, nd, dc;
    int pc[8];
    logic [DW+TW-1:0] first;
    bit f;
    logic [DW+TW-1:0] td;
    do_reset;
    np = 0;
    nd = 0;
    dc = 0;
    first = '0;
    push(word(32'h1234_5678, 1));
    for (int c = 0; c < (MAXR + 3) * (TMO + 1); c++) begin
      if (bus.network_data_ready_out) begin
        if (np == 0) first = bus.network_data_tag_out;
        if (np < 8) pc[np] = c;
        np++;
      end
      if (bus.drop_out) begin
        nd++;
        dc = c;
      end
      tick;
    end
    checks++;
    if (np != MAXR + 1) begin
      fails++;
      $display("FAIL retry_count got %0d want %0d", np, MAXR + 1);
    end
    checks++;
    if (first !== {8'h00, 32'h1234_5678}) begin
      fails++;
      $display("FAIL retry_tag got %h want %h",
               first, {8'h00, 32'h1234_5678});
    end
    for (int i = 1; i < np && i < 8; i++) begin
      checks++;
      if (pc[i] - pc[i-1] != TMO + 1) begin
        fails++;
        $display("FAIL retry_gap%0d got %0d want %0d",
                 i, pc[i] - pc[i-1], TMO + 1);
      end
    end
    checks++;
    if (nd != 1 || np < 1 || np > 8 || dc - pc[np-1] != TMO + 1) begin
      fails++;
      $display("FAIL drop_timing got n=%0d at %0d want 1 at %0d",
               nd, dc, (np >= 1 && np <= 8) ? pc[np-1] + TMO + 1 : -1);
    end
    push(word(32'hA0A0_0001, 1));
    wait_send(4, f, td);
    checks++;
    if (f !== 1'b1 || td !== {8'h01, 32'hA0A0_0001}) begin
      fails++;
      $display("FAIL drop_empty got %b/%h want 1/%h",
               f, td, {8'h01, 32'hA0A0_0001});
    end
    if (f) do_ack;
  endtask

  task automatic test_overflow;
    logic [DW-1:0] d;
    logic [DW+TW-1:0] td;
    bit f;
    int s, dr;
    do_reset;
    for (int i = 0; i < DEP + 1; i++) begin
      d = $urandom;
      push(word(d, 1));
      if (i < DEP) begin
        q.push_back({seq[TW-1:0], d});
        seq++;
      end
      checks++;
      if (bus.overflow_out !== (i == DEP)) begin
        fails++;
        $display("FAIL overflow_%0d got %b want %b",
                 i, bus.overflow_out, i == DEP);
      end
    end
    for (int k = 0; k < DEP; k++) begin
      wait_send(40, f, td);
      checks++;
      if (f !== 1'b1 || td !== q[0]) begin
        fails++;
        $display("FAIL order_%0d got %b/%h want 1/%h", k, f, td, q[0]);
      end
      void'(q.pop_front());
      if (f) do_ack;
    end
    count_activity(40, s, dr);
    checks++;
    if (s != 0 || dr != 0) begin
      fails++;
      $display("FAIL overflow_lost got %0d/%0d want 0/0", s, dr);
    end
    d = $urandom;
    push(word(d, 1));
    wait_send(4, f, td);
    checks++;
    if (f !== 1'b1 || td !== {seq[TW-1:0], d}) begin
      fails++;
      $display("FAIL overflow_seq got %b/%h want 1/%h",
               f, td, {seq[TW-1:0], d});
    end
    if (f) do_ack;
  endtask

  task automatic rx_step(input bit v, input logic [TW-1:0] t,
                         input logic [DW-1:0] d);
    bit deliver;
    bus.network_data_ready_in = v;
    bus.network_data_tag_in = {t, d};
    tick;
    bus.network_data_ready_in = 1'b0;
    deliver = v && !(last_valid && t == last_tag);
    if (deliver) begin
      held = d;
      last_tag = t;
      last_valid = 1'b1;
    end
    checks++;
    if (bus.network_ACK_out !== v
        || bus.host_data_ready_out !== deliver
        || bus.host_data_out !== held) begin
      fails++;
      $display("FAIL rx got ack=%b rdy=%b data=%h want %b/%b/%h",
               bus.network_ACK_out, bus.host_data_ready_out,
               bus.host_data_out, v, deliver, held);
    end
  endtask

  task automatic test_rx;
    int acks, dels;
    logic [DW-1:0] got[$];
    do_reset;
    acks = 0;
    dels = 0;
    bus.network_data_ready_in = 1'b1;
    bus.network_data_tag_in = {8'h07, 32'hDEAD_BEEF};
    tick;
    if (bus.network_ACK_out) acks++;
    if (bus.host_data_ready_out) begin dels++; got.push_back(bus.host_data_out); end
    tick;
    if (bus.network_ACK_out) acks++;
    if (bus.host_data_ready_out) begin dels++; got.push_back(bus.host_data_out); end
    bus.network_data_tag_in = {8'h08, 32'h0000_0001};
    tick;
    bus.network_data_ready_in = 1'b0;
    if (bus.network_ACK_out) acks++;
    if (bus.host_data_ready_out) begin dels++; got.push_back(bus.host_data_out); end
    tick;
    checks++;
    if (acks != 3 || dels != 2) begin
      fails++;
      $display("FAIL rx_dup got acks=%0d dels=%0d want 3/2", acks, dels);
    end
    checks++;
    if (got.size() != 2 || got[0] !== 32'hDEAD_BEEF
        || got[1] !== 32'h0000_0001) begin
      fails++;
      $display("FAIL rx_data got %0d words want DEADBEEF,00000001",
               got.size());
    end
    last_valid = 1'b1;
    last_tag = 8'h08;
    held = 32'h0000_0001;
    for (int i = 0; i < 150; i++)
      rx_step(1'($urandom_range(0, 1)), TW'($urandom_range(0, 3)),
              $urandom);
  endtask

  task automatic test_random_host;
    bit ok, f;
    logic [DW-1:0] d;
    logic [DW+TW-1:0] td;
    do_reset;
    for (int i = 0; i < 270; i++) begin
      ok = ($urandom_range(0, 3) != 0);
      d = $urandom;
      push(word(d, ok));
      checks++;
      if (bus.parity_error_out !== !ok) begin
        fails++;
        $display("FAIL host_parity_%0d got %b want %b",
                 i, bus.parity_error_out, !ok);
      end
      wait_send(4, f, td);
      checks++;
      if (f !== ok || (ok && td !== {seq[TW-1:0], d})) begin
        fails++;
        $display("FAIL host_send_%0d got %b/%h want %b/%h",
                 i, f, td, ok, {seq[TW-1:0], d});
      end
      if (ok) seq = (seq + 1) % (1 << TW);
      if (f) do_ack;
    end
  endtask

  task automatic test_ack_timeout;
    bit f;
    logic [DW+TW-1:0] td;
    int s, dr;
    do_reset;
    push(word(32'h5555_AAAA, 1));
    wait_send(4, f, td);
    for (int i = 0; i < TMO; i++) tick;
    bus.network_ACK_in = 1'b1;
    tick;
    bus.network_ACK_in = 1'b0;
    count_activity(60, s, dr);
    checks++;
    if (f !== 1'b1 || s != 0 || dr != 0) begin
      fails++;
      $display("FAIL ack_at_timeout got sent=%b re=%0d drop=%0d want 1/0/0",
               f, s, dr);
    end
    push(word(32'h0000_0042, 1));
    wait_send(4, f, td);
    checks++;
    if (f !== 1'b1 || td !== {8'h01, 32'h0000_0042}) begin
      fails++;
      $display("FAIL ack_at_timeout_pop got %b/%h want 1/%h",
               f, td, {8'h01, 32'h0000_0042});
    end
    if (f) do_ack;
  endtask

  task automatic test_reset_mid;
    bit f;
    logic [DW-1:0] d;
    logic [DW+TW-1:0] td;
    do_reset;
    bus.network_data_ready_in = 1'b1;
    bus.network_data_tag_in = {8'h05, 32'hCAFE_F00D};
    tick;
    bus.network_data_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) push(word($urandom, 1));
    tick;
    tick;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== '0) begin
      fails++;
      $display("FAIL reset_mid got %h want 0", outs());
    end
    tick;
    reset = 1'b0;
    model_reset;
    d = $urandom;
    push(word(d, 1));
    wait_send(4, f, td);
    checks++;
    if (f !== 1'b1 || td !== {8'h00, d}) begin
      fails++;
      $display("FAIL reset_mid_tag got %b/%h want 1/%h", f, td, {8'h00, d});
    end
    if (f) do_ack;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_parity;
    test_retry;
    test_overflow;
    test_rx;
    test_random_host;
    test_ack_timeout;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
